// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, one full-subtractor cell plus borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_nxt;
    logic [WIDTH-1:0] sr_nxt;

    // Full-subtractor cell on the current LSBs; the new difference bit enters the result MSB
    always_comb begin
        bit_a  = sa[0];
        bit_b  = sb[0];
        bit_d  = bit_a ^ bit_b ^ br;
        br_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
        sr_nxt = {bit_d, sr[WIDTH-1:1]};
    end

    // Control FSM and datapath; busy/done are registered so no input reaches an output combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            DIFF  <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        br    <= Bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    sr  <= sr_nxt;
                    br  <= br_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        DIFF  <= sr_nxt;
                        Bout  <= br_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8 and exhaustive WIDTH=4
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int busy_len8 = 0;
    int overlap_viol = 0;
    int stab_viol = 0;
    int unexp_done = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .DIFF(diff8), .Bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Bin(bin4),
        .busy(busy4), .done(done4), .DIFF(diff4), .Bout(bout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor for the 8-bit instance: pops the scoreboard on each done pulse
    logic [7:0] prev_diff8 = '0;
    logic       prev_rst8 = 1'b1;
    always @(negedge clk) begin
        if (busy8 && done8) overlap_viol++;
        if (!done8 && !prev_rst8 && diff8 !== prev_diff8) stab_viol++;
        if (rst) busy_len8 = 0;
        else if (busy8) busy_len8++;
        if (done8) begin
            if (q8.size() == 0) begin
                unexp_done++;
                $display("FAIL done8_unexpected: got DIFF 0x%0h with no pending operation", diff8);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("result8 {DIFF,Bout}", 32'({diff8, bout8}), 32'(e));
                chk("busy8_len", 32'(busy_len8), 32'd8);
            end
            busy_len8 = 0;
        end
        prev_diff8 = diff8;
        prev_rst8  = rst;
    end

    // Monitor for the 4-bit instance
    logic [3:0] prev_diff4 = '0;
    logic       prev_rst4 = 1'b1;
    always @(negedge clk) begin
        if (busy4 && done4) overlap_viol++;
        if (!done4 && !prev_rst4 && diff4 !== prev_diff4) stab_viol++;
        if (done4) begin
            if (q4.size() == 0) begin
                unexp_done++;
                $display("FAIL done4_unexpected: got DIFF 0x%0h with no pending operation", diff4);
            end else begin
                logic [4:0] e;
                e = q4.pop_front();
                chk("result4 {DIFF,Bout}", 32'({diff4, bout4}), 32'(e));
            end
        end
        prev_diff4 = diff4;
        prev_rst4  = rst;
    end

    task automatic wait_done8(output int at);
        int n;
        at = -1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done8) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done8_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done4();
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done4) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done4_timeout", 32'd0, 32'd1);
    endtask

    // Issue one 8-bit op from IDLE, with a hand-computed expected {DIFF,Bout}
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic [8:0] exp);
        int t;
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; bin8 = ~bi;
        wait_done8(t);
        @(posedge clk); #1;
    endtask

    initial begin
        int t1, t2;
        logic [4:0] ref4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_diff", 32'(diff8), 32'd0);
        chk("reset_bout", 32'(bout8), 32'd0);
        @(posedge clk); #1;

        // Directed vectors: expected {DIFF, Bout}
        op8(8'h5A, 8'h3C, 1'b0, {8'h1E, 1'b0});
        op8(8'h00, 8'h01, 1'b0, {8'hFF, 1'b1});
        op8(8'h10, 8'h0F, 1'b1, {8'h00, 1'b0});
        op8(8'h00, 8'hFF, 1'b1, {8'h00, 1'b1});
        op8(8'hFF, 8'h00, 1'b0, {8'hFF, 1'b0});
        op8(8'h80, 8'h80, 1'b1, {8'hFF, 1'b1});

        // Start pulse during RUN cycle 3 must be ignored
        a8 = 8'hC8; b8 = 8'h64; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back({8'h64, 1'b0});
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(t1);
        repeat (14) @(posedge clk);
        #1;
        chk("ignored_start_queue_empty", 32'(q8.size()), 32'd0);

        // Start held high: back-to-back accepts exactly 10 cycles apart
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back({8'h22, 1'b0});
        q8.push_back({8'h22, 1'b0});
        wait_done8(t1);
        wait_done8(t2);
        start8 = 1'b0;
        chk("held_start_spacing", 32'(t2 - t1), 32'd10);
        repeat (14) @(posedge clk);
        #1;
        chk("held_start_queue_empty", 32'(q8.size()), 32'd0);

        // Reset at RUN cycle 4 aborts with no done pulse
        a8 = 8'h77; b8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 32'(busy8), 32'd0);
        chk("midreset_done", 32'(done8), 32'd0);
        chk("midreset_diff", 32'(diff8), 32'd0);
        chk("midreset_bout", 32'(bout8), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        chk("midreset_no_done", 32'(unexp_done), 32'd0);
        op8(8'h77, 8'h22, 1'b0, {8'h55, 1'b0});

        // Exhaustive 4-bit sweep against the arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    ref4[4:1] = 4'((a - b - c) & 15);
                    ref4[0]   = (a < b + c);
                    a4 = 4'(a); b4 = 4'(b); bin4 = c[0]; start4 = 1'b1;
                    q4.push_back(ref4);
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    a4 = ~a4; b4 = ~b4; bin4 = ~bin4;
                    wait_done4();
                    @(posedge clk); #1;
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue8_drained", 32'(q8.size()), 32'd0);
        chk("queue4_drained", 32'(q4.size()), 32'd0);
        chk("busy_done_overlap", 32'(overlap_viol), 32'd0);
        chk("diff_stable_between_done", 32'(stab_viol), 32'd0);
        chk("unexpected_done_total", 32'(unexp_done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
